// File: rtl/multi_mode_counter.sv
// Run-time selectable up/down/ring/Johnson counter: one register stage, with clear, load, modulus, tc and illegal-state repair.
// Build macro MMC_SATURATE_EN makes the binary modes hold at their end value instead of wrapping.
module multi_mode_counter #(
  parameter int         WIDTH    = 4,
  parameter int         MODULUS  = 2**WIDTH,
  parameter logic [1:0] RST_MODE = 2'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             state_err
);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_RING = 2'd2;
  localparam logic [1:0] MODE_JOHN = 2'd3;

  // One extra bit so MODULUS = 2**WIDTH yields an all-ones top value.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_EXT  = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP      = TOP_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MMC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             mode_chg;
  logic             at_top, at_zero;
  logic             ring_ok, john_ok;
  logic [WIDTH-1:0] count_inv;
  logic [WIDTH-1:0] step_val;
  logic             step_err;
  logic             tc_dec;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    case (m)
      MODE_DOWN: return TOP;
      MODE_RING: return ONE;
      default:   return '0;
    endcase
  endfunction

  assign mode_chg = (mode != mode_q);

  always_comb begin
    at_top    = ({1'b0, count_q} >= TOP_EXT);
    at_zero   = (count_q == '0);
    count_inv = ~count_q;
    ring_ok   = $onehot(count_q);
    // Johnson legal states are a run of low ones (0..01..1) or its complement (1..10..0).
    john_ok   = ((count_q & (count_q + ONE)) == '0) ||
                ((count_inv & (count_inv + ONE)) == '0);
  end

  always_comb begin
    step_val = count_q;
    step_err = 1'b0;
    case (mode_q)
      MODE_UP: begin
        if (at_top) step_val = SATURATE ? TOP : '0;
        else        step_val = count_q + ONE;
      end
      MODE_DOWN: begin
        if (at_zero) step_val = SATURATE ? '0 : TOP;
        else         step_val = count_q - ONE;
      end
      MODE_RING: begin
        if (!ring_ok) begin
          step_val = seed(MODE_RING);
          step_err = 1'b1;
        end else begin
          step_val = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
        end
      end
      default: begin
        if (!john_ok) begin
          step_val = seed(MODE_JOHN);
          step_err = 1'b1;
        end else begin
          step_val = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        end
      end
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      count_d = seed(mode_q);
      err_d   = 1'b0;
    end else if (load) begin
      // Binary loads are clamped into range; ring/Johnson loads are repaired on the next step.
      if (!mode_q[1] && ({1'b0, load_val} >= MOD_EXT)) count_d = TOP;
      else                                              count_d = load_val;
    end else if (mode_chg) begin
      mode_d  = mode;
      count_d = seed(mode);
    end else if (en) begin
      count_d = step_val;
      if (step_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= RST_MODE;
      count_q <= seed(RST_MODE);
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_UP:   tc_dec = (count_q == TOP);
      MODE_DOWN: tc_dec = at_zero;
      default:   tc_dec = (count_q == MSB_ONLY);
    endcase
  end

  assign tc        = en && !mode_chg && tc_dec;
  assign count     = count_q;
  assign state_err = err_q;

endmodule
